// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU op codes and arbiter FSM states.
package alu_pkg;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 5;
   localparam int MAX_OP = 10;
   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_AND  = 2;
   localparam int OP_OR   = 3;
   localparam int OP_XOR  = 4;
   localparam int OP_SLL  = 5;
   localparam int OP_SRL  = 6;
   localparam int OP_SRA  = 7;
   localparam int OP_SLT  = 8;
   localparam int OP_SLTU = 9;
   localparam int OP_NOR  = 10;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   function automatic int id_width(int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; shift amounts use the low log2(W) bits of in2, unknown codes give 0.
module alu import alu_pkg::*; #(
   parameter int W  = 32,
   parameter int CW = 5
) (
   input  logic [W-1:0]  in1,
   input  logic [W-1:0]  in2,
   input  logic [CW-1:0] alu_ctrl,
   output logic [W-1:0]  out
);
   localparam int SW = $clog2(W);
   logic [SW-1:0] sh;
   assign sh = in2[SW-1:0];
   always_comb begin
      out = '0;
      case (int'(alu_ctrl))
         OP_ADD:  out = in1 + in2;
         OP_SUB:  out = in1 - in2;
         OP_AND:  out = in1 & in2;
         OP_OR:   out = in1 | in2;
         OP_XOR:  out = in1 ^ in2;
         OP_SLL:  out = in1 << sh;
         OP_SRL:  out = in1 >> sh;
         OP_SRA:  out = $signed(in1) >>> sh;
         OP_SLT:  out = W'($signed(in1) < $signed(in2));
         OP_SLTU: out = W'(in1 < in2);
         OP_NOR:  out = ~(in1 | in2);
         default: out = '0;
      endcase
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first valid requester at or after ptr.
module rr_arbiter import alu_pkg::*; #(
   parameter int N  = 2,
   parameter int IW = id_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant_oh,
   output logic [IW-1:0] grant_idx,
   output logic          any
);
   logic [IW-1:0] idx;
   // descending scan so the smallest offset from ptr wins
   always_comb begin
      idx = '0;
      grant_idx = '0;
      any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            grant_idx = idx;
            any = 1'b1;
         end
      end
      grant_oh = any ? N'(1) << grant_idx : '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among N_REQ requesters with round-robin
// valid/ready arbitration and a registered, tagged response.
module alu_arbiter #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int CTRL_W = alu_pkg::CTRL_W,
   parameter int MAX_OP = alu_pkg::MAX_OP,
   localparam int ID_W  = alu_pkg::id_width(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*DATA_W-1:0]  req_in1,
   input  logic [N_REQ*DATA_W-1:0]  req_in2,
   input  logic [N_REQ*CTRL_W-1:0]  req_ctrl,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_err,
   input  logic                     rsp_ready,
   output logic                     busy
);
   import alu_pkg::*;
   state_t state;
   logic [ID_W-1:0] rr_ptr, grant_idx;
   logic [N_REQ-1:0] grant_oh;
   logic any;
   logic [DATA_W-1:0] in1_q, in2_q, alu_out;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] a [N_REQ];
   logic [DATA_W-1:0] b [N_REQ];
   logic [CTRL_W-1:0] c [N_REQ];
   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign a[i] = req_in1[i*DATA_W +: DATA_W];
      assign b[i] = req_in2[i*DATA_W +: DATA_W];
      assign c[i] = req_ctrl[i*CTRL_W +: CTRL_W];
   end
   rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
      .req(req_valid), .ptr(rr_ptr), .grant_oh(grant_oh), .grant_idx(grant_idx), .any(any)
   );
   alu #(.W(DATA_W), .CW(CTRL_W)) u_alu (
      .in1(in1_q), .in2(in2_q), .alu_ctrl(ctrl_q), .out(alu_out)
   );
   assign req_ready = (state == IDLE) ? grant_oh : '0;
   assign busy = state != IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         in1_q <= '0;
         in2_q <= '0;
         ctrl_q <= '0;
         rsp_valid <= 1'b0;
         rsp_id <= '0;
         rsp_data <= '0;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any) begin
               in1_q <= a[grant_idx];
               in2_q <= b[grant_idx];
               ctrl_q <= c[grant_idx];
               rsp_id <= grant_idx;
               rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
               state <= EXEC;
            end
            EXEC: begin
               rsp_err <= int'(ctrl_q) > MAX_OP;
               rsp_data <= (int'(ctrl_q) > MAX_OP) ? '0 : alu_out;
               rsp_valid <= 1'b1;
               state <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
